exec_sched: RTL

- Command-driven sequencer for the ALU-array execute stage.
- Accepts one vector job: opcode, element count, source row address and destination row address.
- Fetches operand rows of ALU_NUM elements, issues each row to the execute stage with a per-lane enable mask, waits for the stage's all-lanes-valid, then writes the result row.
- Sits between the instruction decoder and the operand/result buffers.

---
 rtl/exec_sched.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/exec_sched.sv
`default_nettype none
// ============================================================================
// Module   : exec_sched
// Brief    : Row sequencer for the ALU-array execute stage. Reads an operand
//            row, issues it to the lanes with an enable mask, waits for the
//            all-lanes-valid, then writes the masked result row.
// Options  : EXEC_SCHED_TIMEOUT_EN adds a WAIT-state watchdog and sticky err.
// Revision : 1.0  initial release
// ============================================================================
module exec_sched #(
    parameter int N       = 32,
    parameter int ALU_NUM = 8,
    parameter int AW      = 8,
    parameter int LEN_W   = 12,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_instr,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic [AW-1:0]        cmd_src,
    input  logic [AW-1:0]        cmd_dst,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    input  logic [ALU_NUM*N-1:0] rd_dataA,
    input  logic [ALU_NUM*N-1:0] rd_dataB,
    output logic [ALU_NUM-1:0]   exec_enable,
    output logic [2:0]           exec_instr,
    output logic [ALU_NUM*N-1:0] exec_dataA,
    output logic [ALU_NUM*N-1:0] exec_dataB,
    input  logic                 exec_valid,
    input  logic [ALU_NUM*N-1:0] exec_data,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [ALU_NUM-1:0]   wr_mask,
    output logic [ALU_NUM*N-1:0] wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [LEN_W-1:0] c_ROW_ELEMS = LEN_W'(ALU_NUM);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LOAD  = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                 state_q,     state_d;
    logic [2:0]             instr_q,     instr_d;
    logic [LEN_W-1:0]       rem_q,       rem_d;
    logic [AW-1:0]          src_q,       src_d;
    logic [AW-1:0]          dst_q,       dst_d;
    logic [AW-1:0]          row_q,       row_d;
    logic [ALU_NUM-1:0]     mask_q,      mask_d;
    logic [ALU_NUM*N-1:0]   opa_q,       opa_d;
    logic [ALU_NUM*N-1:0]   opb_q,       opb_d;
    logic                   rd_en_q,     rd_en_d;
    logic [AW-1:0]          rd_addr_q,   rd_addr_d;
    logic [ALU_NUM-1:0]     exec_en_q,   exec_en_d;
    logic                   wr_en_q,     wr_en_d;
    logic [AW-1:0]          wr_addr_q,   wr_addr_d;
    logic [ALU_NUM-1:0]     wr_mask_q,   wr_mask_d;
    logic [ALU_NUM*N-1:0]   wr_data_q,   wr_data_d;
    logic                   busy_q,      busy_d;
    logic                   done_q,      done_d;
    logic                   cmd_ready_q, cmd_ready_d;

    logic [ALU_NUM-1:0]     w_lane_mask;
    logic [ALU_NUM*N-1:0]   w_exec_masked;
    logic [LEN_W-1:0]       w_step;

`ifdef EXEC_SCHED_TIMEOUT_EN
    localparam int c_WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    logic [c_WD_W-1:0] wd_q, wd_d;
    logic              err_q, err_d;

    assign err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign err            = 1'b0;
`endif

    // Lane i is live while more than i elements remain; dead lanes write zero.
    for (genvar i = 0; i < ALU_NUM; i++) begin : g_lane
        assign w_lane_mask[i]          = (rem_q > LEN_W'(i));
        assign w_exec_masked[i*N +: N] = mask_q[i] ? exec_data[i*N +: N] : '0;
    end

    assign w_step = (rem_q >= c_ROW_ELEMS) ? c_ROW_ELEMS : rem_q;

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        rem_d     = rem_q;
        src_d     = src_q;
        dst_d     = dst_q;
        row_d     = row_q;
        mask_d    = mask_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        wr_addr_d = '0;
        wr_mask_d = '0;
        wr_data_d = '0;
`ifdef EXEC_SCHED_TIMEOUT_EN
        wd_d      = wd_q;
        err_d     = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    instr_d = cmd_instr;
                    rem_d   = cmd_len;
                    src_d   = cmd_src;
                    dst_d   = cmd_dst;
                    row_d   = '0;
                    state_d = (cmd_len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                opa_d   = rd_dataA;
                opb_d   = rd_dataB;
                mask_d  = w_lane_mask;
                state_d = S_WAIT;
`ifdef EXEC_SCHED_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            S_WAIT: begin
                if (exec_valid) begin
                    wr_addr_d = dst_q + row_q;
                    wr_mask_d = mask_q;
                    wr_data_d = w_exec_masked;
                    state_d   = S_WRITE;
                end else begin
`ifdef EXEC_SCHED_TIMEOUT_EN
                    // Abandon the whole job: no write for this row, no later rows.
                    if (wd_q == c_WD_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
`endif
                end
            end
            S_WRITE: begin
                row_d   = row_q + 1'b1;
                rem_d   = rem_q - w_step;
                state_d = (rem_d == '0) ? S_DONE : S_READ;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes are registered from the next state so they line up with it.
        rd_en_d     = (state_d == S_READ);
        rd_addr_d   = rd_en_d ? (src_d + row_d) : '0;
        exec_en_d   = (state_d == S_WAIT) ? mask_d : '0;
        wr_en_d     = (state_d == S_WRITE);
        busy_d      = (state_d != S_IDLE);
        cmd_ready_d = (state_d == S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            instr_q     <= '0;
            rem_q       <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            row_q       <= '0;
            mask_q      <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            exec_en_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_mask_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
`ifdef EXEC_SCHED_TIMEOUT_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            rem_q       <= rem_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            row_q       <= row_d;
            mask_q      <= mask_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            exec_en_q   <= exec_en_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_mask_q   <= wr_mask_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
`ifdef EXEC_SCHED_TIMEOUT_EN
            wd_q        <= wd_d;
            err_q       <= err_d;
`endif
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign exec_enable = exec_en_q;
    assign exec_instr  = instr_q;
    assign exec_dataA  = opa_q;
    assign exec_dataB  = opb_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_mask     = wr_mask_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

`default_nettype wire
